range_scan_ctrl: RTL
====================

// Module: range_scan_ctrl
// PURPOSE
//  Sequencer for the enRange predicate. Holds a DEPTH-entry element table and accepts one range command at a time.
//  Scans every entry in order, one entry per cycle, and applies the enRange predicate to it.
//  Streams each matching index/value on a valid/ready port, then pulses done with the match count.
//  Sits between the host command interface and the downstream result consumer.
// PARAMETERS
//  DEPTH  16  number of table entries (power of two, >=2)
//  IDX_W  4   log2(DEPTH); width of entry index
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      reset, asynchronous assert, active-low
//  wr_en        in   1      table write strobe (honoured only in IDLE)
//  wr_addr      in   IDX_W  entry to write
//  wr_eltDef    in   1      entry defined flag
//  wr_isMeta    in   1      entry carries metadata
//  wr_metadata  in   8      entry metadata byte
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      block idle, command accepted on valid&ready
//  cmd_handle   in   8      handle to match against metadata
//  cmd_low      in   8      low bound / value when not metadata
//  cmd_high     in   8      high bound / value when metadata
//  res_valid    out  1      result available
//  res_ready    in   1      consumer accepts result
//  res_index    out  IDX_W  index of matching entry
//  res_value    out  8      resultValue of matching entry
//  done         out  1      one-cycle pulse, scan complete
//  done_count   out  IDX_W+1  matches emitted in last scan (valid while done=1, held after)
//  busy         out  1      high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; all table entries cleared (eltDef=isMeta=0, metadata=0).
//    On reset, res_valid=0, res_index=0, res_value=0, done=0, done_count=0, busy=0 and cmd_ready=1.
//  - Predicate per entry e: match = e.isMeta && (e.metadata <= 7) && e.eltDef && (e.metadata == cmd_handle).
//    value = e.isMeta ? high : low. Because a match requires isMeta, emitted values always equal the latched high.
//  - handle/low/high are latched on command acceptance; later changes on cmd_* are ignored until IDLE.
//  - FSM states: IDLE, SCAN, EMIT, DONE.
//  - IDLE: cmd_ready=1. Writes take effect next cycle. cmd_valid&cmd_ready -> SCAN with idx=0 and cnt=0.
//  - SCAN: evaluate entry[idx].
//      * match: load res_index=idx and res_value, cnt+=1, go to EMIT.
//      * no match and idx==DEPTH-1: go to DONE.
//      * no match otherwise: idx+=1 and stay in SCAN.
//  - EMIT: res_valid=1 with res_index and res_value held stable.
//      * res_valid&res_ready: res_valid drops next cycle; go to DONE if idx==DEPTH-1, else idx+=1 and go to SCAN.
//      * no handshake: stay in EMIT.
//  - DONE: done=1 for exactly one cycle, done_count=cnt, then IDLE. done_count holds until the next DONE or reset.
//  - Timing: command accepted at cycle T; entry k is evaluated at T+1+k+(number of stall/emit cycles before k).
//    With zero matches, done=1 at T+DEPTH+1 and cmd_ready=1 again at T+DEPTH+2.
//    Each match costs at least 1 extra cycle (the EMIT cycle).
//  - wr_en is ignored when busy=1, with no side effect; cmd_valid while busy is not accepted (cmd_ready=0).
//  - Index arithmetic: idx never wraps. The compare with DEPTH-1 ends the scan, so cnt <= DEPTH and fits IDX_W+1 bits.
//  - Reset mid-operation (any state): immediate return to IDLE, outputs to reset values, table cleared, no done pulse.
// TESTING
//  1. Reset, no writes, cmd handle=3 at T -> no res_valid, done=1 at T+17 with done_count=0, cmd_ready=1 at T+18.
//  2. Write entries 2 and 5 {def=1,isMeta=1,meta=3}; entry 7 {def=1,isMeta=0,meta=3}; entry 9 {def=1,isMeta=1,meta=9}.
//     Then cmd handle=3, low=0x11, high=0xAA, res_ready=1 -> results (2,0xAA),(5,0xAA) only; done_count=2.
//  3. As test 2, but hold res_ready=0 for 5 cycles on the first result -> res_valid, index 2 and 0xAA stable all 5 cycles.
//     Both results still delivered in order; done_count=2.
//  4. During a scan, wr_en to entry 4 with meta=3 and cmd_valid=1 -> entry 4 not reported and the command is not accepted.
//     A second scan after IDLE still shows entry 4 undefined.
//  5. Entry 15 {def=1,isMeta=1,meta=0}, cmd handle=0 -> single result index 15, then done with done_count=1, no idx wrap.
//  6. Assert rst_n=0 while in EMIT -> res_valid=0 and busy=0 asynchronously, no done pulse.
//     A new scan afterwards returns done_count=0.

Source files
------------

// File: rtl/range_scan_ctrl.sv
// rtl/range_scan_ctrl.sv - enRange predicate scan sequencer over a DEPTH-entry table
// Scans the table one entry per cycle, streams matches, then pulses done with the count.
module range_scan_ctrl #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic             wr_eltDef,
   input  logic             wr_isMeta,
   input  logic [7:0]       wr_metadata,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_handle,
   input  logic [7:0]       cmd_low,
   input  logic [7:0]       cmd_high,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [IDX_W-1:0] res_index,
   output logic [7:0]       res_value,
   output logic             done,
   output logic [IDX_W:0]   done_count,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [DEPTH-1:0] def_q, def_d, ismeta_q, ismeta_d;
   logic [7:0]       meta_q [DEPTH];
   logic [7:0]       meta_d [DEPTH];
   logic [IDX_W-1:0] idx_q, idx_d, res_index_q, res_index_d;
   logic [IDX_W:0]   cnt_q, cnt_d, done_count_q, done_count_d;
   logic [7:0]       handle_q, handle_d, low_q, low_d, high_q, high_d;
   logic [7:0]       res_value_q, res_value_d;
   logic             cur_match, last_idx;
   logic [7:0]       cur_value;

   assign cur_match = ismeta_q[idx_q] && (meta_q[idx_q] <= 8'd7) && def_q[idx_q]
                      && (meta_q[idx_q] == handle_q);
   assign cur_value = ismeta_q[idx_q] ? high_q : low_q;
   assign last_idx  = (idx_q == IDX_W'(DEPTH - 1));

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign res_valid  = (state_q == S_EMIT);
   assign done       = (state_q == S_DONE);
   assign res_index  = res_index_q;
   assign res_value  = res_value_q;
   assign done_count = done_count_q;

   // Table is only writable while idle so a scan always sees a frozen snapshot.
   always_comb begin
      def_d    = def_q;
      ismeta_d = ismeta_q;
      for (int i = 0; i < DEPTH; i++) meta_d[i] = meta_q[i];
      if (wr_en && (state_q == S_IDLE)) begin
         def_d[wr_addr]    = wr_eltDef;
         ismeta_d[wr_addr] = wr_isMeta;
         meta_d[wr_addr]   = wr_metadata;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      handle_d     = handle_q;
      low_d        = low_q;
      high_d       = high_q;
      res_index_d  = res_index_q;
      res_value_d  = res_value_q;
      done_count_d = done_count_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d  = S_SCAN;
               idx_d    = '0;
               cnt_d    = '0;
               handle_d = cmd_handle;
               low_d    = cmd_low;
               high_d   = cmd_high;
            end
         end
         S_SCAN: begin
            if (cur_match) begin
               res_index_d = idx_q;
               res_value_d = cur_value;
               cnt_d       = cnt_q + {{IDX_W{1'b0}}, 1'b1};
               state_d     = S_EMIT;
            end else if (last_idx) begin
               done_count_d = cnt_q;
               state_d      = S_DONE;
            end else begin
               idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         S_EMIT: begin
            if (res_ready) begin
               if (last_idx) begin
                  done_count_d = cnt_q;
                  state_d      = S_DONE;
               end else begin
                  idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                  state_d = S_SCAN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         def_q        <= '0;
         ismeta_q     <= '0;
         for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         handle_q     <= '0;
         low_q        <= '0;
         high_q       <= '0;
         res_index_q  <= '0;
         res_value_q  <= '0;
         done_count_q <= '0;
      end else begin
         state_q      <= state_d;
         def_q        <= def_d;
         ismeta_q     <= ismeta_d;
         for (int i = 0; i < DEPTH; i++) meta_q[i] <= meta_d[i];
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         handle_q     <= handle_d;
         low_q        <= low_d;
         high_q       <= high_d;
         res_index_q  <= res_index_d;
         res_value_q  <= res_value_d;
         done_count_q <= done_count_d;
      end
   end

endmodule
